// File: rtl/l_accum.sv
// l_accum: iterative L-transform accumulator fed by registered per-byte lookup tables.
// Define L_ACCUM_SBOX_EN to place the pi S-box in the address path (computes L(S(x))).
module l_accum #(
  parameter int unsigned W  = 128,
  parameter int unsigned NB = W / 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_dat,
  output logic [3:0]   tbl_sel,
  output logic [7:0]   tbl_addr,
  input  logic [W-1:0] tbl_dat,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_dat
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  localparam logic [3:0] LastCnt = 4'(NB - 1);

`ifdef L_ACCUM_SBOX_EN
  localparam int unsigned Pi [256] = '{
    252, 238, 221,  17, 207, 110,  49,  22, 251, 196, 250, 218,  35, 197,   4,  77,
    233, 119, 240, 219, 147,  46, 153, 186,  23,  54, 241, 187,  20, 205,  95, 193,
    249,  24, 101,  90, 226,  92, 239,  33, 129,  28,  60,  66, 139,   1, 142,  79,
      5, 132,   2, 174, 227, 106, 143, 160,   6,  11, 237, 152, 127, 212, 211,  31,
    235,  52,  44,  81, 234, 200,  72, 171, 242,  42, 104, 162, 253,  58, 206, 204,
    181, 112,  14,  86,   8,  12, 118,  18, 191, 114,  19,  71, 156, 183,  93, 135,
     21, 161, 150,  41,  16, 123, 154, 199, 243, 145, 120, 111, 157, 158, 178, 177,
     50, 117,  25,  61, 255,  53, 138, 126, 109,  84, 198, 128, 195, 189,  13,  87,
    223, 245,  36, 169,  62, 168,  67, 201, 215, 121, 214, 246, 124,  34, 185,   3,
    224,  15, 236, 222, 122, 148, 176, 188, 220, 232,  40,  80,  78,  51,  10,  74,
    167, 151,  96, 115,  30,   0,  98,  68,  26, 184,  56, 130, 100, 159,  38,  65,
    173,  69,  70, 146,  39,  94,  85,  47, 140, 163, 165, 125, 105, 213, 149,  59,
      7,  88, 179,  64, 134, 172,  29, 247,  48,  55, 107, 228, 136, 217, 231, 137,
    225,  27, 131,  73,  76,  63, 248, 254, 141,  83, 170, 144, 202, 216, 133,  97,
     32, 113, 103, 164,  45,  43,   9,  91, 203, 155,  37, 208, 190, 229, 108,  82,
     89, 166, 116, 210, 230, 244, 180, 192, 209, 102, 175, 194,  57,  75,  99, 182
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return 8'(Pi[b]);
  endfunction
`else
  function automatic logic [7:0] sub_byte(input logic [7:0] b);
    return b;
  endfunction
`endif

  state_e       state_q, state_d;
  logic [W-1:0] sr_q, sr_d;
  logic [W-1:0] acc_q, acc_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   sel_q, sel_d;
  logic [7:0]   addr_q, addr_d;
  logic         pend_q, pend_d;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    pend_d  = 1'b0;

    // pend_q marks the cycle in which the word addressed one cycle earlier is on tbl_dat.
    if (pend_q) begin
      acc_d = acc_q ^ tbl_dat;
    end

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Byte 0 is presented straight away; the rest shift down one per issue cycle.
          sr_d    = in_dat >> 8;
          acc_d   = '0;
          cnt_d   = '0;
          sel_d   = '0;
          addr_d  = sub_byte(in_dat[7:0]);
          state_d = StIssue;
        end
      end
      StIssue: begin
        pend_d = 1'b1;
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = StDrain;
        end else begin
          cnt_d  = cnt_q + 4'd1;
          sel_d  = cnt_q + 4'd1;
          addr_d = sub_byte(sr_q[7:0]);
          sr_d   = sr_q >> 8;
        end
      end
      StDrain: begin
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
    end
  end

  assign in_ready  = (state_q == StIdle) && !reset;
  assign out_valid = (state_q == StDone);
  assign out_dat   = acc_q;
  assign tbl_sel   = sel_q;
  assign tbl_addr  = addr_q;

endmodule
